w5500_tx_scheduler: RTL

Byte-stream packetizer and transmit sequencer in front of the W5500 UDP send path (`w5500_top`). It buffers a sample byte stream in an internal FIFO and groups the bytes into UDP payloads of fixed size. It issues one send request per payload, or a short payload when a timeout expires. It serves the engine's byte read strobes from the FIFO and enforces an inter-packet gap, which replaces the ad-hoc one-byte-per-request flag logic.

---
 rtl/w5500_pkg.sv | 18 +
 rtl/sync_fifo_fwft.sv | 57 +++++
 rtl/w5500_tx_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/w5500_pkg.sv
// Shared types and constants for the W5500 UDP transmit path.
package w5500_pkg;

  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int LEN_W           = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Saturating 16-bit increment, used by the dropped-byte counter.
  function automatic logic [LEN_W-1:0] sat_inc16(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; dout shows the head byte, 0 when empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage has no reset; emptiness is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/w5500_tx_scheduler.sv
// Packetizes a byte stream into UDP payloads for the W5500 send engine.
// Handshake: in_vld pushes a byte every cycle it is high (no backpressure; bytes
// arriving while full are dropped and counted). o_dat_tx_req is held high with a
// stable o_dat_len until dat_tx_end; each dat_tx_rden consumes the byte on o_dat
// in that same cycle.
module w5500_tx_scheduler
  import w5500_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int PKT_LEN = 64,
  parameter int TIMEOUT = 50000,
  parameter int GAP_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [7:0]               in_dat,
  output logic                     o_dat_tx_req,
  output logic [LEN_W-1:0]         o_dat_len,
  input  logic                     dat_tx_rden,
  output logic [7:0]               o_dat,
  input  logic                     dat_tx_end,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [15:0]              o_ovf_cnt,
  output logic                     o_err,
  output state_t                   dbg_state
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYC + 1);

  localparam logic [LEN_W-1:0] PKT_LEN_W = LEN_W'(PKT_LEN);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYC - 1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic [LEN_W-1:0] remain, remain_nxt;
  logic [LEN_W-1:0] rem_after;
  logic [TW-1:0]    tmo, tmo_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic [15:0]      ovf_cnt;
  logic             err;
  logic             err_set;
  logic             pop;

  logic [LW-1:0]    fifo_level;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LEN_W-1:0] level_w;
  logic             full_rdy;

  sync_fifo_fwft #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_vld),
    .pop   (pop),
    .din   (in_dat),
    .dout  (o_dat),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign level_w  = LEN_W'(fifo_level);
  assign full_rdy = (level_w >= PKT_LEN_W);

  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    remain_nxt = remain;
    rem_after  = remain;
    tmo_nxt    = tmo;
    gap_nxt    = gap_cnt;
    err_set    = 1'b0;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (dat_tx_end) err_set = 1'b1;
        if (full_rdy) begin
          state_nxt  = SEND;
          len_nxt    = PKT_LEN_W;
          remain_nxt = PKT_LEN_W;
          tmo_nxt    = '0;
        end else if (level_w != '0) begin
          if (tmo == TMO_LAST) begin
            state_nxt  = SEND;
            len_nxt    = level_w;
            remain_nxt = level_w;
            tmo_nxt    = '0;
          end else begin
            tmo_nxt = tmo + TW'(1);
          end
        end else begin
          tmo_nxt = '0;
        end
      end

      SEND: begin
        // The pop of this cycle is accounted before a coincident end.
        if (dat_tx_rden) begin
          if (remain != '0) begin
            pop       = 1'b1;
            rem_after = remain - LEN_W'(1);
          end else begin
            err_set = 1'b1;
          end
        end
        remain_nxt = rem_after;
        if (dat_tx_end) begin
          state_nxt = GAP;
          gap_nxt   = '0;
          if (rem_after != '0) err_set = 1'b1;
        end
      end

      GAP: begin
        if (dat_tx_end) err_set = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          // Last dead cycle doubles as the IDLE launch check, so a waiting full
          // payload is requested exactly GAP_CYC cycles after the request drops.
          gap_nxt = '0;
          if (full_rdy) begin
            state_nxt  = SEND;
            len_nxt    = PKT_LEN_W;
            remain_nxt = PKT_LEN_W;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len     <= '0;
      remain  <= '0;
      tmo     <= '0;
      gap_cnt <= '0;
      ovf_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      len     <= len_nxt;
      remain  <= remain_nxt;
      tmo     <= tmo_nxt;
      gap_cnt <= gap_nxt;
      err     <= err | err_set;
      if (in_vld && fifo_full) begin
        ovf_cnt <= sat_inc16(ovf_cnt);
      end
    end
  end

  assign o_dat_tx_req = (state == SEND);
  assign o_dat_len    = len;
  assign o_busy       = (state != IDLE);
  assign o_level      = fifo_level;
  assign o_ovf_cnt    = ovf_cnt;
  assign o_err        = err;
  assign dbg_state    = state;

endmodule
